// File: rtl/lms_coeff_engine.sv
// LMS coefficient-update engine: one (error, sample-vector) request per handshake,
// applied tap by tap through a single time-shared multiplier with leak, freeze and clamp.
module lms_coeff_engine #(
    parameter int BIT_WIDTH  = 16,
    parameter int TAPS       = 8,
    parameter int LEAK_SHIFT = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [BIT_WIDTH-1:0]    error_in,
    input  logic [TAPS*BIT_WIDTH-1:0]      x_flat,
    input  logic [$clog2(2*BIT_WIDTH)-1:0] mu_shift,
    input  logic                           leak_en,
    input  logic                           freeze,
    input  logic                           clear,
    output logic [TAPS*BIT_WIDTH-1:0]      coeff_flat,
    output logic                           busy,
    output logic                           upd_done,
    output logic                           sat_any
);

    localparam int MU_W  = $clog2(2 * BIT_WIDTH);
    localparam int IDX_W = $clog2(TAPS);
    localparam int PW    = 2 * BIT_WIDTH;
    localparam int SW    = 2 * BIT_WIDTH + 1;

    localparam logic signed [SW-1:0] SUM_MAX = {{(BIT_WIDTH + 2){1'b0}}, {(BIT_WIDTH - 1){1'b1}}};
    localparam logic signed [SW-1:0] SUM_MIN = {{(BIT_WIDTH + 2){1'b1}}, {(BIT_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q;
    logic                        sat_q;
    logic signed [BIT_WIDTH-1:0] coeff_q [TAPS];

    // Latched copies of the request; the live inputs are ignored once accepted.
    logic signed [BIT_WIDTH-1:0] err_q;
    logic signed [BIT_WIDTH-1:0] x_q [TAPS];
    logic [MU_W-1:0]             mu_q;
    logic                        leak_q;
    logic                        frz_q;

    logic                        accept;
    logic                        last_tap;
    logic signed [BIT_WIDTH-1:0] c_cur;
    logic signed [BIT_WIDTH-1:0] leak_term;
    logic signed [BIT_WIDTH:0]   base;
    logic signed [PW-1:0]        prod;
    logic signed [PW-1:0]        delta;
    logic signed [SW-1:0]        sum;
    logic signed [BIT_WIDTH-1:0] clamped;
    logic                        sat_now;

    assign in_ready = (state_q == IDLE) && !rst;
    assign accept   = in_valid && in_ready && !clear;
    assign last_tap = (idx_q == IDX_W'(TAPS - 1));
    assign busy     = (state_q != IDLE);
    assign upd_done = (state_q == DONE);
    assign sat_any  = (state_q == DONE) && sat_q;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = UPDATE;
            UPDATE:  if (last_tap) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    // Per-tap datapath: multiply, arithmetic shift, optional leak, then clamp at full width.
    always_comb begin
        c_cur     = coeff_q[idx_q];
        leak_term = c_cur >>> LEAK_SHIFT;
        base      = leak_q ? (BIT_WIDTH + 1)'(c_cur) - (BIT_WIDTH + 1)'(leak_term)
                           : (BIT_WIDTH + 1)'(c_cur);
        prod      = PW'(err_q) * PW'(x_q[idx_q]);
        delta     = prod >>> mu_q;
        sum       = SW'(base) + SW'(delta);
        clamped   = sum[BIT_WIDTH-1:0];
        sat_now   = 1'b0;
        if (sum > SUM_MAX) begin
            clamped = SUM_MAX[BIT_WIDTH-1:0];
            sat_now = 1'b1;
        end else if (sum < SUM_MIN) begin
            clamped = SUM_MIN[BIT_WIDTH-1:0];
            sat_now = 1'b1;
        end
    end

    // NOTE: the coefficient bank is reset even though it is array-shaped: it is a register bank driven straight onto coeff_flat, not a RAM.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sat_q   <= 1'b0;
            err_q   <= '0;
            mu_q    <= '0;
            leak_q  <= 1'b0;
            frz_q   <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                coeff_q[i] <= '0;
                x_q[i]     <= '0;
            end
        end else begin
            state_q <= state_d;
            if (clear) begin
                idx_q <= '0;
                sat_q <= 1'b0;
                for (int i = 0; i < TAPS; i++) coeff_q[i] <= '0;
            end else if (accept) begin
                err_q  <= error_in;
                mu_q   <= mu_shift;
                leak_q <= leak_en;
                frz_q  <= freeze;
                idx_q  <= '0;
                sat_q  <= 1'b0;
                for (int i = 0; i < TAPS; i++) x_q[i] <= x_flat[i*BIT_WIDTH +: BIT_WIDTH];
            end else if (state_q == UPDATE) begin
                if (!frz_q) begin
                    coeff_q[idx_q] <= clamped;
                    if (sat_now) sat_q <= 1'b1;
                end
                if (!last_tap) idx_q <= idx_q + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < TAPS; g++) begin : g_pack
        assign coeff_flat[g*BIT_WIDTH +: BIT_WIDTH] = coeff_q[g];
    end

endmodule

// File: tb/tb_lms_coeff_engine.sv
// Directed self-checking bench for lms_coeff_engine (BIT_WIDTH=16, TAPS=8, LEAK_SHIFT=4).
module tb_lms_coeff_engine;

    localparam int W = 16;
    localparam int T = 8;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  error_in;
    logic [T*W-1:0]       x_flat;
    logic [4:0]           mu_shift;
    logic                 leak_en;
    logic                 freeze;
    logic                 clear;
    logic [T*W-1:0]       coeff_flat;
    logic                 busy;
    logic                 upd_done;
    logic                 sat_any;

    int errors = 0;
    int checks = 0;

    lms_coeff_engine #(.BIT_WIDTH(W), .TAPS(T), .LEAK_SHIFT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .error_in   (error_in),
        .x_flat     (x_flat),
        .mu_shift   (mu_shift),
        .leak_en    (leak_en),
        .freeze     (freeze),
        .clear      (clear),
        .coeff_flat (coeff_flat),
        .busy       (busy),
        .upd_done   (upd_done),
        .sat_any    (sat_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [W-1:0] tap(input int i);
        return coeff_flat[i*W +: W];
    endfunction

    function automatic logic [T*W-1:0] ramp(input int m);
        logic [T*W-1:0] r;
        for (int i = 0; i < T; i++) r[i*W +: W] = W'(m * i);
        return r;
    endfunction

    function automatic logic [T*W-1:0] flat_const(input logic [W-1:0] v);
        logic [T*W-1:0] r;
        for (int i = 0; i < T; i++) r[i*W +: W] = v;
        return r;
    endfunction

    task automatic clear_pulse();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Issues one request and follows it until in_ready returns; cycle 1 is the cycle after the accept edge.
    task automatic run_update(input logic signed [W-1:0] e, input logic [T*W-1:0] x,
                              input logic [4:0] mu, input logic lk, input logic fz,
                              input bit scramble, output int done_at, output int rdy_at,
                              output int done_cnt, output logic sat);
        error_in = e;
        x_flat   = x;
        mu_shift = mu;
        leak_en  = lk;
        freeze   = fz;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: in_ready=%b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        if (scramble) begin
            error_in = 16'sh7fff;
            x_flat   = flat_const(16'h7fff);
            mu_shift = 5'd0;
            leak_en  = 1'b1;
            freeze   = 1'b1;
        end
        done_at  = 0;
        rdy_at   = 0;
        done_cnt = 0;
        sat      = 1'bx;
        for (int cyc = 1; cyc <= 30 && rdy_at == 0; cyc++) begin
            if (upd_done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at = cyc;
                    sat     = sat_any;
                end
            end
            if (in_ready === 1'b1) rdy_at = cyc;
            else step();
        end
        freeze  = 1'b0;
        leak_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, busy, upd_done, sat_any} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/busy/done/sat=%b expected 0000", {in_ready, busy, upd_done, sat_any});
        end
        checks++;
        if (coeff_flat !== '0) begin
            errors++;
            $display("FAIL reset_coeffs: coeff_flat=%h expected 0", coeff_flat);
        end
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        int da, ra, dc;
        logic s;
        run_update(16'sd256, ramp(4), 5'd8, 1'b0, 1'b0, 1'b0, da, ra, dc, s);
        checks++;
        if (da != 9) begin
            errors++;
            $display("FAIL basic_done_latency: upd_done at cycle %0d expected 9", da);
        end
        checks++;
        if (ra != 10) begin
            errors++;
            $display("FAIL basic_ready_return: in_ready back at cycle %0d expected 10", ra);
        end
        checks++;
        if (dc != 1) begin
            errors++;
            $display("FAIL basic_done_pulses: %0d pulses expected 1", dc);
        end
        checks++;
        if (s !== 1'b0) begin
            errors++;
            $display("FAIL basic_sat: sat_any=%b expected 0", s);
        end
        for (int i = 0; i < T; i++) begin
            checks++;
            if (tap(i) !== W'(4 * i)) begin
                errors++;
                $display("FAIL basic_coeff[%0d]: got %0d expected %0d", i, tap(i), 4 * i);
            end
        end
    endtask

    task automatic test_saturation();
        int da, ra, dc;
        logic s;
        run_update(16'sh7fff, flat_const(16'h7fff), 5'd0, 1'b0, 1'b0, 1'b0, da, ra, dc, s);
        checks++;
        if (s !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos_flag: sat_any=%b expected 1", s);
        end
        for (int i = 0; i < T; i++) begin
            checks++;
            if (tap(i) !== 16'sh7fff) begin
                errors++;
                $display("FAIL sat_pos_coeff[%0d]: got %0d expected 32767", i, tap(i));
            end
        end
        run_update(-16'sd32768, flat_const(16'h7fff), 5'd0, 1'b0, 1'b0, 1'b0, da, ra, dc, s);
        checks++;
        if (s !== 1'b1 || da != 9) begin
            errors++;
            $display("FAIL sat_neg_flag: sat_any=%b done_at=%0d expected 1 and 9", s, da);
        end
        for (int i = 0; i < T; i++) begin
            checks++;
            if (tap(i) !== 16'sh8000) begin
                errors++;
                $display("FAIL sat_neg_coeff[%0d]: got %0d expected -32768", i, tap(i));
            end
        end
    endtask

    task automatic test_round_leak();
        int da, ra, dc;
        logic s;
        clear_pulse();
        run_update(-16'sd1, flat_const(16'h0001), 5'd8, 1'b0, 1'b0, 1'b0, da, ra, dc, s);
        for (int i = 0; i < T; i++) begin
            checks++;
            if (tap(i) !== -16'sd1) begin
                errors++;
                $display("FAIL round_floor_coeff[%0d]: got %0d expected -1", i, tap(i));
            end
        end
        run_update(16'sh7fff, flat_const(16'h7fff), 5'd0, 1'b0, 1'b0, 1'b0, da, ra, dc, s);
        run_update(16'sd0, flat_const(16'h1234), 5'd0, 1'b1, 1'b0, 1'b0, da, ra, dc, s);
        checks++;
        if (s !== 1'b0) begin
            errors++;
            $display("FAIL leak_sat: sat_any=%b expected 0", s);
        end
        for (int i = 0; i < T; i++) begin
            checks++;
            if (tap(i) !== 16'sd30720) begin
                errors++;
                $display("FAIL leak_coeff[%0d]: got %0d expected 30720", i, tap(i));
            end
        end
    endtask

    task automatic test_freeze();
        int da, ra, dc;
        logic s;
        run_update(16'sd1000, flat_const(16'd1000), 5'd0, 1'b1, 1'b1, 1'b0, da, ra, dc, s);
        checks++;
        if (da != 9 || dc != 1) begin
            errors++;
            $display("FAIL freeze_done: done_at=%0d pulses=%0d expected 9 and 1", da, dc);
        end
        checks++;
        if (s !== 1'b0) begin
            errors++;
            $display("FAIL freeze_sat: sat_any=%b expected 0", s);
        end
        for (int i = 0; i < T; i++) begin
            checks++;
            if (tap(i) !== 16'sd30720) begin
                errors++;
                $display("FAIL freeze_coeff[%0d]: got %0d expected 30720", i, tap(i));
            end
        end
    endtask

    task automatic test_input_hold();
        int da, ra, dc;
        logic s;
        clear_pulse();
        run_update(16'sd2, ramp(1), 5'd1, 1'b0, 1'b0, 1'b1, da, ra, dc, s);
        checks++;
        if (s !== 1'b0) begin
            errors++;
            $display("FAIL hold_sat: sat_any=%b expected 0", s);
        end
        for (int i = 0; i < T; i++) begin
            checks++;
            if (tap(i) !== W'(i)) begin
                errors++;
                $display("FAIL hold_coeff[%0d]: got %0d expected %0d", i, tap(i), i);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc [3];
        int n = 0;
        int ready_seen = 0;
        clear_pulse();
        error_in = 16'sd16;
        x_flat   = ramp(1);
        mu_shift = 5'd4;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && n < 3; cyc++) begin
            if (in_ready === 1'b1) begin
                acc[n] = cyc;
                n++;
            end
            step();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 20 && ready_seen == 0; k++) begin
            if (in_ready === 1'b1) ready_seen = 1;
            else step();
        end
        checks++;
        if (n != 3 || ready_seen == 0) begin
            errors++;
            $display("FAIL b2b_accepts: accepts=%0d ready_seen=%0d expected 3 and 1", n, ready_seen);
        end else begin
            for (int j = 1; j < 3; j++) begin
                checks++;
                if (acc[j] - acc[j-1] != 10) begin
                    errors++;
                    $display("FAIL b2b_spacing[%0d]: gap %0d expected 10", j, acc[j] - acc[j-1]);
                end
            end
        end
        for (int i = 0; i < T; i++) begin
            checks++;
            if (tap(i) !== W'(3 * i)) begin
                errors++;
                $display("FAIL b2b_coeff[%0d]: got %0d expected %0d", i, tap(i), 3 * i);
            end
        end
    endtask

    task automatic test_clear_mid();
        int pulses = 0;
        error_in = 16'sd256;
        x_flat   = ramp(4);
        mu_shift = 5'd8;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        checks++;
        if (tap(1) !== 16'sd7 || tap(2) !== 16'sd6) begin
            errors++;
            $display("FAIL clear_midvisible: tap1=%0d tap2=%0d expected 7 and 6", tap(1), tap(2));
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (coeff_flat !== '0) begin
            errors++;
            $display("FAIL clear_coeffs: coeff_flat=%h expected 0", coeff_flat);
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready: in_ready=%b busy=%b expected 1 and 0", in_ready, busy);
        end
        for (int k = 0; k < 12; k++) begin
            if (upd_done === 1'b1) pulses++;
            step();
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL clear_no_done: %0d pulses expected 0", pulses);
        end
        clear    = 1'b1;
        in_valid = 1'b1;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_blocks_accept: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        error_in = 16'sd256;
        x_flat   = ramp(4);
        mu_shift = 5'd8;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        checks++;
        if (tap(3) !== 16'sd12) begin
            errors++;
            $display("FAIL rstmid_pre_tap3: got %0d expected 12", tap(3));
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (coeff_flat !== '0) begin
            errors++;
            $display("FAIL rstmid_coeffs: coeff_flat=%h expected 0", coeff_flat);
        end
        checks++;
        if ({in_ready, busy, upd_done, sat_any} !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_ctrl: ready/busy/done/sat=%b expected 0000", {in_ready, busy, upd_done, sat_any});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (upd_done === 1'b1) pulses++;
            step();
        end
        checks++;
        if (pulses != 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_after: pulses=%0d in_ready=%b expected 0 and 1", pulses, in_ready);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        error_in = '0;
        x_flat   = '0;
        mu_shift = '0;
        leak_en  = 1'b0;
        freeze   = 1'b0;
        clear    = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_round_leak();
        test_freeze();
        test_input_hold();
        test_back_to_back();
        test_clear_mid();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
